// File: rtl/attn_score_row_streamer.sv
// Attention score row streamer.
// Captures a ROWS x COLS matrix of signed Q2.14 scores on a single-cycle valid
// pulse, then replays it one row per handshake. Before each row is presented,
// its elements are scanned one per cycle to find the signed row maximum, which
// travels alongside the row for the downstream softmax max-subtraction.
//
// Handshake semantics (output side): a row transfers on every rising edge
// where o_valid && i_ready. While o_valid && !i_ready, every row output
// (o_row_data, o_row_max, o_row_idx, o_last) holds stable. o_valid never
// drops without a transfer. i_ready while o_valid is low has no effect.
// Input side: o_in_ready is high only in IDLE; an i_valid pulse seen in any
// other state is discarded and reported with a one-cycle o_drop pulse.
module attn_score_row_streamer #(
  parameter int ROWS       = 32,
  parameter int COLS       = 32,
  parameter int DATA_WIDTH = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_valid,
  input  logic [ROWS*COLS*DATA_WIDTH-1:0] i_matrix,
  output logic                           o_in_ready,
  output logic                           o_drop,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [COLS*DATA_WIDTH-1:0]     o_row_data,
  output logic [DATA_WIDTH-1:0]          o_row_max,
  output logic [$clog2(ROWS)-1:0]        o_row_idx,
  output logic                           o_last
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  localparam logic [RW-1:0]         LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0]         LAST_COL = CW'(COLS - 1);
  localparam logic [DATA_WIDTH-1:0] MIN_VAL  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  typedef logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] matrix_t;

  // FSM state; kept as a named enum so checkers can bind to it directly
  state_t state_q;
  state_t state_d;

  matrix_t                 mat_q;
  logic [RW-1:0]           row_q;
  logic [CW-1:0]           col_q;
  logic [DATA_WIDTH-1:0]   max_q;

  logic                    capture;
  logic                    scan_done;
  logic                    handshake;
  logic [DATA_WIDTH-1:0]   cur_elem;
  logic [DATA_WIDTH-1:0]   scan_max;

  // Element under scan and the running maximum including it; ties keep the
  // earlier value, which is bit-identical anyway
  always_comb begin
    cur_elem = mat_q[row_q][col_q];
    if ($signed(cur_elem) > $signed(max_q)) begin
      scan_max = cur_elem;
    end else begin
      scan_max = max_q;
    end
  end

  assign capture   = (state_q == ST_IDLE) && i_valid;
  assign scan_done = (state_q == ST_SCAN) && (col_q == LAST_COL);
  assign handshake = (state_q == ST_OUT) && i_ready;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_valid) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (col_q == LAST_COL) state_d = ST_OUT;
      end
      ST_OUT: begin
        if (i_ready) begin
          if (o_last) state_d = ST_IDLE;
          else        state_d = ST_SCAN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    o_in_ready = 1'b0;
    o_valid    = 1'b0;
    unique case (state_q)
      ST_IDLE: o_in_ready = 1'b1;
      ST_SCAN: ;
      ST_OUT:  o_valid    = 1'b1;
      default: ;
    endcase
  end

  // Matrix buffer: written only on capture, untouched by dropped pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mat_q <= '0;
    end else if (capture) begin
      mat_q <= matrix_t'(i_matrix);
    end
  end

  // Row/column scan counters and running maximum
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      row_q <= '0;
      col_q <= '0;
      max_q <= '0;
    end else if (capture) begin
      row_q <= '0;
      col_q <= '0;
      max_q <= MIN_VAL;
    end else if (state_q == ST_SCAN) begin
      max_q <= scan_max;
      if (col_q == LAST_COL) begin
        col_q <= '0;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end else if (handshake && !o_last) begin
      row_q <= row_q + 1'b1;
      col_q <= '0;
      max_q <= MIN_VAL;
    end
  end

  // Row outputs, loaded on the last scan cycle and held through backpressure
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_row_data <= '0;
      o_row_max  <= '0;
      o_row_idx  <= '0;
      o_last     <= 1'b0;
    end else if (scan_done) begin
      o_row_data <= mat_q[row_q];
      o_row_max  <= scan_max;
      o_row_idx  <= row_q;
      o_last     <= (row_q == LAST_ROW);
    end else if (handshake) begin
      o_last     <= 1'b0;
    end
  end

  // Drop indicator: any i_valid outside IDLE pulses o_drop the following cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_drop <= 1'b0;
    end else begin
      o_drop <= i_valid && (state_q != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_attn_score_row_streamer.sv
// Bench for attn_score_row_streamer: frame-level reference model plus
// directed scenarios (streaming, extremes, backpressure, drops, mid-frame
// reset, back-to-back frames) and randomized ready/stray-valid frames.
module tb_attn_score_row_streamer;

  localparam int ROWS = 32;
  localparam int COLS = 32;
  localparam int DW   = 16;
  localparam int RW   = $clog2(ROWS);
  localparam int W    = COLS * DW;

  typedef logic [ROWS-1:0][COLS-1:0][DW-1:0] mat_t;

  // ---------------- clock / reset ----------------
  logic          i_clk   = 1'b0;
  logic          i_rst_n = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_ready = 1'b1;
  mat_t          i_matrix = '0;
  logic          o_in_ready;
  logic          o_drop;
  logic          o_valid;
  logic [W-1:0]  o_row_data;
  logic [DW-1:0] o_row_max;
  logic [RW-1:0] o_row_idx;
  logic          o_last;

  always #5 i_clk = ~i_clk;

  attn_score_row_streamer #(
    .ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_valid(i_valid),
    .i_matrix(i_matrix),
    .o_in_ready(o_in_ready),
    .o_drop(o_drop),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_row_data(o_row_data),
    .o_row_max(o_row_max),
    .o_row_idx(o_row_idx),
    .o_last(o_last)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] row_max_of(input mat_t m, input int r);
    logic signed [DW-1:0] best;
    best = m[r][0];
    for (int c = 1; c < COLS; c++) begin
      if ($signed(m[r][c]) > best) best = m[r][c];
    end
    return best;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        m[r][c] = DW'($urandom_range(0, 65535));
    return m;
  endfunction

  // ---------------- reference model ----------------
  // Frame-level view: a captured matrix, the row being presented, and how many
  // edges remain before that row becomes visible.
  bit   m_busy = 1'b0;
  int   m_wait = 0;
  int   m_row  = 0;
  bit   m_drop = 1'b0;
  mat_t m_mat  = '0;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_busy = 1'b0;
      m_wait = 0;
      m_row  = 0;
      m_drop = 1'b0;
    end else begin
      m_drop = i_valid && m_busy;
      if (!m_busy) begin
        if (i_valid) begin
          m_mat  = i_matrix;
          m_busy = 1'b1;
          m_row  = 0;
          m_wait = COLS;
        end
      end else if (m_wait == 0) begin
        if (i_ready) begin
          if (m_row == ROWS - 1) begin
            m_busy = 1'b0;
          end else begin
            m_row++;
            m_wait = COLS;
          end
        end
      end else begin
        m_wait--;
      end
    end
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  logic [W-1:0] exp_q[$];

  always @(negedge i_clk) begin
    exp_q.delete();
    exp_q.push_back(W'(!m_busy));
    exp_q.push_back(W'(m_busy && m_wait == 0));
    exp_q.push_back(W'(m_drop));
    check("in_ready", W'(o_in_ready), exp_q[0]);
    check("valid",    W'(o_valid),    exp_q[1]);
    check("drop",     W'(o_drop),     exp_q[2]);
    if (m_busy && m_wait == 0) begin
      check("row_data", o_row_data, W'(m_mat[m_row]));
      check("row_max",  W'(o_row_max), W'(row_max_of(m_mat, m_row)));
      check("row_idx",  W'(o_row_idx), W'(m_row));
      check("last",     W'(o_last),    W'(m_row == ROWS - 1));
    end
  end

  int drop_seen = 0;
  always @(negedge i_clk) if (o_drop) drop_seen++;

  // ---------------- ready driver ----------------
  int hold_cnt   = 0;
  bit rand_ready = 1'b0;

  always @(negedge i_clk) begin
    if (hold_cnt > 0) begin
      i_ready = 1'b0;
      hold_cnt--;
    end else if (rand_ready) begin
      i_ready = 1'($urandom_range(0, 1));
    end else begin
      i_ready = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse(input mat_t m);
    @(negedge i_clk);
    i_valid  = 1'b1;
    i_matrix = m;
    @(negedge i_clk);
    i_valid  = 1'b0;
  endtask

  // Advance edge by edge (sampling #1 after each) until o_valid; returns edge count
  task automatic wait_row(output int edges);
    edges = 0;
    do begin
      @(posedge i_clk);
      #1;
      edges++;
    end while (!o_valid && edges < 3000);
    if (!o_valid) check("row_timeout", W'(o_valid), W'(1));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy && n < 8000) begin
      @(negedge i_clk);
      n++;
    end
    check("idle_timeout", W'(m_busy), W'(0));
    repeat (2) @(negedge i_clk);
  endtask

  // ---------------- main sequence ----------------
  mat_t m1, m2, m3, m4, m5, m6a, m6b;
  int   e;

  initial begin
    #2 i_rst_n = 1'b0;
    #1;
    check("rst_valid",    W'(o_valid),    W'(0));
    check("rst_in_ready", W'(o_in_ready), W'(1));
    check("rst_drop",     W'(o_drop),     W'(0));
    check("rst_last",     W'(o_last),     W'(0));
    check("rst_data",     o_row_data,     W'(0));
    check("rst_max",      W'(o_row_max),  W'(0));
    check("rst_idx",      W'(o_row_idx),  W'(0));
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    // 1. ramp matrix, ready high
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        m1[r][c] = DW'(r * 64 + c);
    pulse(m1);
    for (int r = 0; r < ROWS; r++) begin
      wait_row(e);
      check("t1_latency", W'(e), W'(r == 0 ? 32 : 33));
      check("t1_max",  W'(o_row_max), W'(DW'(r * 64 + 31)));
      check("t1_idx",  W'(o_row_idx), W'(r));
      check("t1_last", W'(o_last),    W'(r == ROWS - 1));
    end
    wait_idle();

    // 2. negative extremes
    m2 = rand_mat();
    for (int c = 0; c < COLS; c++) begin
      m2[0][c] = 16'h8000;
      m2[1][c] = 16'h8000;
      m2[2][c] = 16'hFFFF;
    end
    m2[1][COLS-1] = 16'h7FFF;
    pulse(m2);
    wait_row(e);
    check("t2_all_min", W'(o_row_max), W'(16'h8000));
    wait_row(e);
    check("t2_one_max", W'(o_row_max), W'(16'h7FFF));
    wait_row(e);
    check("t2_all_m1",  W'(o_row_max), W'(16'hFFFF));
    wait_idle();

    // 3. backpressure on row 5
    m3 = rand_mat();
    pulse(m3);
    for (int r = 0; r <= 5; r++) wait_row(e);
    hold_cnt = 10;
    for (int k = 0; k < 10; k++) begin
      @(posedge i_clk);
      #1;
      check("t3_hold_valid", W'(o_valid),   W'(1));
      check("t3_hold_idx",   W'(o_row_idx), W'(5));
      check("t3_hold_max",   W'(o_row_max), W'(row_max_of(m3, 5)));
      check("t3_hold_data",  o_row_data,    W'(m3[5]));
    end
    wait_row(e);
    check("t3_release_lat", W'(e), W'(33));
    check("t3_next_idx", W'(o_row_idx), W'(6));
    wait_idle();

    // 4. drops during scan of row 3 and on the final handshake
    m4 = rand_mat();
    pulse(m4);
    e = 0;
    while (!(m_busy && m_row == 3 && m_wait > 5 && m_wait < 20) && e < 3000) begin
      @(negedge i_clk);
      e++;
    end
    drop_seen = 0;
    pulse(rand_mat());
    repeat (3) @(negedge i_clk);
    check("t4_scan_drop", W'(drop_seen), W'(1));
    e = 0;
    do begin
      wait_row(e);
    end while (!o_last && o_valid);
    drop_seen = 0;
    pulse(rand_mat());
    repeat (3) @(negedge i_clk);
    check("t4_final_drop", W'(drop_seen), W'(1));
    check("t4_idle_ready", W'(o_in_ready), W'(1));
    check("t4_no_capture", W'(o_valid),    W'(0));
    wait_idle();

    // 5. reset during OUT of row 12
    m5 = rand_mat();
    pulse(m5);
    do begin
      wait_row(e);
    end while (o_valid && o_row_idx != RW'(12));
    #2 i_rst_n = 1'b0;
    #1;
    check("t5_valid",    W'(o_valid),    W'(0));
    check("t5_in_ready", W'(o_in_ready), W'(1));
    check("t5_last",     W'(o_last),     W'(0));
    check("t5_data",     o_row_data,     W'(0));
    check("t5_max",      W'(o_row_max),  W'(0));
    check("t5_idx",      W'(o_row_idx),  W'(0));
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    m5 = rand_mat();
    pulse(m5);
    wait_row(e);
    check("t5_restart_lat", W'(e), W'(32));
    check("t5_restart_idx", W'(o_row_idx), W'(0));
    wait_idle();

    // 6. back-to-back frames
    m6a = rand_mat();
    m6b = rand_mat();
    pulse(m6a);
    do begin
      wait_row(e);
    end while (!o_last && o_valid);
    @(posedge i_clk);
    pulse(m6b);
    check("t6_accepted", W'(o_in_ready), W'(0));
    wait_row(e);
    check("t6_lat", W'(e), W'(32));
    check("t6_idx", W'(o_row_idx), W'(0));
    check("t6_max", W'(o_row_max), W'(row_max_of(m6b, 0)));
    wait_idle();

    // 7. random ready with stray valid pulses
    rand_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      pulse(rand_mat());
      e = 0;
      while (m_busy && e < 20000) begin
        @(negedge i_clk);
        i_matrix = rand_mat();
        i_valid  = (m_row < ROWS - 2) && ($urandom_range(0, 19) == 0);
        e++;
      end
      i_valid = 1'b0;
      check("t7_done", W'(m_busy), W'(0));
      repeat (3) @(negedge i_clk);
    end
    rand_ready = 1'b0;
    repeat (3) @(negedge i_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
